tx_frame_serializer: RTL

TX_FRAME_SERIALIZER -- requirements
Module: tx_frame_serializer

---
 rtl/tx_frame_pkg.sv | 15 +
 rtl/tx_chk_accum.sv | 35 +++
 rtl/tx_frame_serializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tx_frame_pkg.sv
// rtl/tx_frame_pkg.sv - shared types and constants for the TX frame serializer
package tx_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      SEQ,
      DATA,
      CHK
   } tx_state_e;

   localparam int          FRAME_OVERHEAD    = 3;
   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h0000_A5A5;

endpackage

// File: rtl/tx_chk_accum.sv
// rtl/tx_chk_accum.sv - running XOR accumulator for the frame check word
module tx_chk_accum #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] acc
);

   logic [DATA_W-1:0] acc_d;
   logic [DATA_W-1:0] acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = acc_q ^ word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/tx_frame_serializer.sv
// rtl/tx_frame_serializer.sv - serializes one multi-channel sample set per frame:
// SYNC, SEQ, CH0..CHn-1, CHK with registered stream outputs.
module tx_frame_serializer
   import tx_frame_pkg::*;
#(
   parameter int                NUM_CH    = 4,
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT[DATA_W-1:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_sof,
   output logic                     out_eof
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   tx_state_e                 state_d, state_q;
   logic [NUM_CH*DATA_W-1:0]  frame_d, frame_q;
   logic [DATA_W-1:0]         seq_d, seq_q;
   logic [IDX_W-1:0]          idx_d, idx_q;
   logic                      out_valid_d, out_valid_q;
   logic [DATA_W-1:0]         out_data_d, out_data_q;
   logic                      out_sof_d, out_sof_q;
   logic                      out_eof_d, out_eof_q;

   logic [DATA_W-1:0]         ch_words [NUM_CH];
   logic [DATA_W-1:0]         chk_acc;
   logic [IDX_W-1:0]          idx_nxt;
   logic                      in_hs;
   logic                      out_hs;

   assign in_ready = !rst && (state_q == IDLE || (state_q == CHK && out_ready));
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;
   assign idx_nxt  = idx_q + IDX_W'(1);

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ch_words[k] = frame_q[k*DATA_W +: DATA_W];
      end
   end

   // The check word covers exactly the words handshaked while in SEQ and DATA.
   tx_chk_accum #(
      .DATA_W (DATA_W)
   ) u_chk_accum (
      .clk    (clk),
      .rst    (rst),
      .clear  (in_hs),
      .enable (out_hs && (state_q == SEQ || state_q == DATA)),
      .word   (out_data_q),
      .acc    (chk_acc)
   );

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      seq_d       = seq_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;

      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
         end
         SYNC: if (out_hs) begin
            state_d    = SEQ;
            out_data_d = seq_q;
            out_sof_d  = 1'b0;
         end
         SEQ: if (out_hs) begin
            state_d    = DATA;
            idx_d      = '0;
            out_data_d = ch_words[0];
         end
         DATA: if (out_hs) begin
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
               // Accumulator lags by one word, so fold in the last channel here.
               state_d    = CHK;
               out_data_d = chk_acc ^ out_data_q;
               out_eof_d  = 1'b1;
            end else begin
               idx_d      = idx_nxt;
               out_data_d = ch_words[idx_nxt];
            end
         end
         CHK: if (out_hs) begin
            state_d     = IDLE;
            seq_d       = seq_q + DATA_W'(1);
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_eof_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // A new sample set overrides CHK->IDLE so frames run back-to-back.
      if (in_hs) begin
         state_d     = SYNC;
         frame_d     = in_data;
         out_valid_d = 1'b1;
         out_data_d  = SYNC_WORD;
         out_sof_d   = 1'b1;
         out_eof_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         seq_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         seq_q       <= seq_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule
